// File: rtl/bpm_estimator.sv
// bpm_estimator: heart-rate estimator for a pulse sensor.
// Samples are checked against a hysteresis threshold pair to detect beats.
// The beat-to-beat interval is measured in 4 ms ticks. A restoring divider
// then turns 15000 / interval into beats per minute.
//
// Ports
//   clk             single clock
//   reset           asynchronous, active-high
//   sample_in       pulse-sensor sample (BITS wide)
//   sample_valid    qualifier for sample_in
//   BPM_estimate    registered BPM, 0 after reset or timeout
//   pulse_amplitude registered peak-to-trough of the last accepted beat
//   bpm_valid       one-cycle strobe when BPM_estimate is written
//   beat_pulse      one-cycle strobe per detected beat
//
// state    | meaning
// S_FIRST  | no prior beat; the next beat only starts interval timing
// S_TRACK  | timing the interval since the last beat
// S_DIVIDE | computing 15000 / interval, one quotient bit per cycle
module bpm_estimator #(
   parameter int BITS          = 8,
   parameter int TICK_CYCLES   = 200000,
   parameter int THRESH_HI     = 160,
   parameter int THRESH_LO     = 96,
   parameter int MIN_TICKS     = 75,
   parameter int MAX_TICKS     = 375,
   parameter int TIMEOUT_TICKS = 500
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BITS-1:0]          sample_in,
   input  logic                     sample_valid,
   output logic [$clog2(201)-1:0]   BPM_estimate,
   output logic [BITS-1:0]          pulse_amplitude,
   output logic                     bpm_valid,
   output logic                     beat_pulse
);

   localparam int BW = $clog2(201);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [BITS-1:0] TH_HI     = BITS'(THRESH_HI);
   localparam logic [BITS-1:0] TH_LO     = BITS'(THRESH_LO);
   localparam logic [8:0]      MIN_T     = 9'(MIN_TICKS);
   localparam logic [8:0]      MAX_T     = 9'(MAX_TICKS);
   localparam logic [8:0]      TMO_T     = 9'(TIMEOUT_TICKS);
   localparam logic [13:0]     DIVIDEND  = 14'd15000;

   typedef enum logic [1:0] {S_FIRST, S_TRACK, S_DIVIDE} state_t;

   state_t            state, state_next;
   logic [TW-1:0]     tick_cnt;
   logic              tick_4ms;
   logic [8:0]        interval;
   logic              armed;
   logic [BITS-1:0]   max_val, min_val, max_next, min_next, amp_next;
   logic              hi_hit, beat, timeout, start_div, div_last;
   logic [8:0]        divisor;
   logic [8:0]        rem;
   logic [13:0]       dvd, quo;
   logic [3:0]        div_step;
   logic [9:0]        trial;
   logic              trial_ge;

   assign tick_4ms = (tick_cnt == '0);
   assign hi_hit   = sample_valid && armed && (sample_in >= TH_HI);
   assign div_last = (div_step == 4'd14);

   // Running extremes include the current sample so the beat sample itself
   // takes part in the peak-to-trough measurement.
   always_comb begin
      max_next = max_val;
      min_next = min_val;
      if (sample_valid) begin
         if (sample_in > max_val) max_next = sample_in;
         if (sample_in < min_val) min_next = sample_in;
      end
      amp_next = (max_next >= min_next) ? (max_next - min_next) : '0;
   end

   always_comb begin
      trial    = {rem, dvd[13]};
      trial_ge = (trial >= {1'b0, divisor});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FIRST;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      beat       = 1'b0;
      timeout    = 1'b0;
      start_div  = 1'b0;
      case (state)
         S_FIRST: begin
            if (hi_hit) begin
               beat       = 1'b1;
               state_next = S_TRACK;
            end
         end
         S_TRACK: begin
            if (hi_hit && (interval >= MIN_T)) begin
               beat = 1'b1;
               if (interval <= MAX_T) begin
                  start_div  = 1'b1;
                  state_next = S_DIVIDE;
               end
            end else if (interval >= TMO_T) begin
               timeout    = 1'b1;
               state_next = S_FIRST;
            end
         end
         S_DIVIDE: begin
            if (div_last) state_next = S_TRACK;
         end
         default: state_next = S_FIRST;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt        <= '0;
         interval        <= '0;
         armed           <= 1'b1;
         max_val         <= '0;
         min_val         <= '1;
         pulse_amplitude <= '0;
         BPM_estimate    <= '0;
         bpm_valid       <= 1'b0;
         beat_pulse      <= 1'b0;
         divisor         <= '0;
         rem             <= '0;
         dvd             <= '0;
         quo             <= '0;
         div_step        <= '0;
      end else begin
         beat_pulse <= beat;
         bpm_valid  <= 1'b0;

         tick_cnt <= tick_4ms ? TICK_LAST : tick_cnt - 1'b1;

         // A beat wins over a coincident tick so the new interval starts at 0.
         if (beat)                               interval <= '0;
         else if (tick_4ms && interval != 9'h1FF) interval <= interval + 1'b1;

         if (beat)                                     armed <= 1'b0;
         else if (sample_valid && sample_in < TH_LO)   armed <= 1'b1;

         if (beat) begin
            pulse_amplitude <= amp_next;
            max_val         <= sample_in;
            min_val         <= sample_in;
         end else begin
            max_val <= max_next;
            min_val <= min_next;
         end

         if (timeout) begin
            BPM_estimate    <= '0;
            pulse_amplitude <= '0;
            bpm_valid       <= 1'b1;
         end

         if (start_div) begin
            divisor  <= interval;
            dvd      <= DIVIDEND;
            rem      <= '0;
            quo      <= '0;
            div_step <= '0;
         end else if (state == S_DIVIDE) begin
            if (!div_last) begin
               rem      <= trial_ge ? 9'(trial - {1'b0, divisor}) : trial[8:0];
               quo      <= {quo[12:0], trial_ge};
               dvd      <= {dvd[12:0], 1'b0};
               div_step <= div_step + 1'b1;
            end else begin
               BPM_estimate <= (quo > 14'd200) ? BW'(200) : quo[BW-1:0];
               bpm_valid    <= 1'b1;
            end
         end
      end
   end

endmodule
